// File: rtl/hs_merge_sync.sv
// hs_merge_sync: merges two 4-phase bundled-data channels onto one valid/ready stream (round-robin).
// Define HS_MERGE_CNT_EN to add saturating per-channel grant counters cnt0_o/cnt1_o.
module hs_merge_sync #(
    parameter int N           = 1,
    parameter int SYNC_STAGES = 2   // legal range 2..4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         r0_i,
    output logic         a0_o,
    input  logic [N-1:0] d0_i,
    input  logic         r1_i,
    output logic         a1_o,
    input  logic [N-1:0] d1_i,
    output logic         valid_o,
    input  logic         ready_i,
    output logic [N-1:0] data_o,
    output logic         sel_o
`ifdef HS_MERGE_CNT_EN
    ,
    output logic [15:0]  cnt0_o,
    output logic [15:0]  cnt1_o
`endif
);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] s0_q, s1_q;
    logic                   r0_s, r1_s;
    logic                   gnt_q, gnt_d;
    logic                   last_q;
    logic                   slot_free;
    logic                   do_grant, do_release;

    // NOTE: all clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            s0_q <= '0;
            s1_q <= '0;
        end else begin
            s0_q <= {s0_q[SYNC_STAGES-2:0], r0_i};
            s1_q <= {s1_q[SYNC_STAGES-2:0], r1_i};
        end
    end

    assign r0_s      = s0_q[SYNC_STAGES-1];
    assign r1_s      = s1_q[SYNC_STAGES-1];
    assign slot_free = !valid_o || ready_i;

    // NOTE: every output of this block gets a default first, so no latch can be inferred.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        do_grant   = 1'b0;
        do_release = 1'b0;
        case (state_q)
            IDLE: begin
                if (slot_free && (r0_s || r1_s)) begin
                    do_grant = 1'b1;
                    gnt_d    = (r0_s && r1_s) ? !last_q : r1_s;
                    state_d  = HOLD;
                end
            end
            HOLD: begin
                if (!(gnt_q ? r1_s : r0_s)) begin
                    do_release = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
            a0_o    <= 1'b0;
            a1_o    <= 1'b0;
            valid_o <= 1'b0;
            data_o  <= '0;
            sel_o   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (do_grant) begin
                // A grant may coincide with a drain; the new word simply replaces the consumed one.
                gnt_q   <= gnt_d;
                last_q  <= gnt_d;
                data_o  <= gnt_d ? d1_i : d0_i;
                sel_o   <= gnt_d;
                valid_o <= 1'b1;
                a0_o    <= !gnt_d;
                a1_o    <= gnt_d;
            end else begin
                if (valid_o && ready_i) begin
                    valid_o <= 1'b0;
                end
                if (do_release) begin
                    a0_o <= 1'b0;
                    a1_o <= 1'b0;
                end
            end
        end
    end

`ifdef HS_MERGE_CNT_EN
    logic [15:0] cnt0_q, cnt1_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt0_q <= 16'd0;
            cnt1_q <= 16'd0;
        end else if (do_grant) begin
            if (!gnt_d && cnt0_q != 16'hFFFF) begin
                cnt0_q <= cnt0_q + 16'd1;
            end
            if (gnt_d && cnt1_q != 16'hFFFF) begin
                cnt1_q <= cnt1_q + 16'd1;
            end
        end
    end

    assign cnt0_o = cnt0_q;
    assign cnt1_o = cnt1_q;
`endif

endmodule

// File: tb/tb_hs_merge_sync.sv
// tb_hs_merge_sync: directed latency/arbitration/back-pressure/reset tests plus random
// 4-phase traffic checked against per-channel expected-word queues.
module tb_hs_merge_sync;

    localparam int N  = 8;
    localparam int SS = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         r0_i = 1'b0, r1_i = 1'b0;
    logic [N-1:0] d0_i = '0, d1_i = '0;
    logic         ready_i = 1'b1;
    logic         a0_o, a1_o, valid_o, sel_o;
    logic [N-1:0] data_o;
`ifdef HS_MERGE_CNT_EN
    logic [15:0]  cnt0_o, cnt1_o;
`endif

    hs_merge_sync #(.N(N), .SYNC_STAGES(SS)) dut (
        .clk     (clk),
        .rst     (rst),
        .r0_i    (r0_i),
        .a0_o    (a0_o),
        .d0_i    (d0_i),
        .r1_i    (r1_i),
        .a1_o    (a1_o),
        .d1_i    (d1_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .data_o  (data_o),
        .sel_o   (sel_o)
`ifdef HS_MERGE_CNT_EN
        ,
        .cnt0_o  (cnt0_o),
        .cnt1_o  (cnt1_o)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: words each upstream has handed over but the stream has not yet delivered.
    logic [N-1:0] exp_q0[$];
    logic [N-1:0] exp_q1[$];
    int           rx_cnt = 0;
    bit           sb_en  = 1'b0;
    bit           log_en = 1'b0;
    int           grant_log[$];
    logic         a0_prev = 1'b0, a1_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Compare process: mutual exclusion every cycle, stream words against the queues.
    always @(negedge clk) begin
        if (a0_o || a1_o) begin
            check("ack_mutex", {31'd0, a0_o & a1_o}, 32'd0);
        end
        if (sb_en && valid_o && ready_i) begin
            if (sel_o == 1'b0) begin
                if (exp_q0.size() == 0) check("sb_extra_word_ch0", {24'd0, data_o}, 32'hFFFF_FFFF);
                else                    check("sb_data_ch0", {24'd0, data_o}, {24'd0, exp_q0.pop_front()});
            end else begin
                if (exp_q1.size() == 0) check("sb_extra_word_ch1", {24'd0, data_o}, 32'hFFFF_FFFF);
                else                    check("sb_data_ch1", {24'd0, data_o}, {24'd0, exp_q1.pop_front()});
            end
            rx_cnt++;
        end
        if (log_en && ((a0_o && !a0_prev) || (a1_o && !a1_prev))) begin
            grant_log.push_back(int'(sel_o));
        end
        a0_prev = a0_o;
        a1_prev = a1_o;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Counts edges (sampling 1 unit after each) until the channel's ack reaches lvl.
    task automatic wait_ack(input bit ch, input logic lvl, input int limit, output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (((ch ? a1_o : a0_o) !== lvl) && n < limit);
    endtask

    task automatic xfer(input bit ch, input logic [N-1:0] d);
        int n;
        if (ch) begin d1_i = d; r1_i = 1'b1; end
        else    begin d0_i = d; r0_i = 1'b1; end
        if (sb_en) begin
            if (ch) exp_q1.push_back(d);
            else    exp_q0.push_back(d);
        end
        wait_ack(ch, 1'b1, 400, n);
        check(ch ? "xfer_ack1_rise" : "xfer_ack0_rise", {31'd0, ch ? a1_o : a0_o}, 32'd1);
        if (ch) r1_i = 1'b0;
        else    r0_i = 1'b0;
        wait_ack(ch, 1'b0, 400, n);
        check(ch ? "xfer_ack1_fall" : "xfer_ack0_fall", {31'd0, ch ? a1_o : a0_o}, 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int  n;
        bit  bp_ok;
        bit  done0, done1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_a0", {31'd0, a0_o}, 32'd0);
        check("rst_a1", {31'd0, a1_o}, 32'd0);
        check("rst_valid", {31'd0, valid_o}, 32'd0);
        check("rst_data", {24'd0, data_o}, 32'd0);
        check("rst_sel", {31'd0, sel_o}, 32'd0);
        rst = 1'b0;

        // Single channel-0 transfer: rise and fall latency SYNC_STAGES+1
        ready_i = 1'b1;
        d0_i    = 8'hA5;
        r0_i    = 1'b1;
        wait_ack(1'b0, 1'b1, 20, n);
        check("single_rise_latency", n, 32'd3);
        check("single_data", {24'd0, data_o}, 32'hA5);
        check("single_sel", {31'd0, sel_o}, 32'd0);
        check("single_valid", {31'd0, valid_o}, 32'd1);
        @(posedge clk);
        #1;
        check("single_valid_one_cycle", {31'd0, valid_o}, 32'd0);
        r0_i = 1'b0;
        wait_ack(1'b0, 1'b0, 20, n);
        check("single_fall_latency", n, 32'd3);

        // Contention: four rounds of simultaneous requests alternate 0,1,...
        do_reset();
        grant_log.delete();
        log_en = 1'b1;
        for (int r = 0; r < 4; r++) begin
            fork
                xfer(1'b0, 8'h11);
                xfer(1'b1, 8'h22);
            join
        end
        log_en = 1'b0;
        check("contention_grant_count", grant_log.size(), 32'd8);
        for (int i = 0; i < grant_log.size() && i < 8; i++) begin
            check("contention_sel", grant_log[i], i % 2);
        end

        // Back-pressure: second word waits, then drain and refill on the same edge
        do_reset();
        ready_i = 1'b0;
        d0_i    = 8'h01;
        r0_i    = 1'b1;
        wait_ack(1'b0, 1'b1, 20, n);
        check("bp_first_grant", {31'd0, a0_o}, 32'd1);
        check("bp_first_data", {24'd0, data_o}, 32'h01);
        d1_i  = 8'h02;
        r1_i  = 1'b1;
        r0_i  = 1'b0;
        bp_ok = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (a1_o !== 1'b0 || valid_o !== 1'b1) bp_ok = 1'b0;
        end
        check("bp_stall_holds", {31'd0, bp_ok}, 32'd1);
        check("bp_a0_released", {31'd0, a0_o}, 32'd0);
        check("bp_word_kept", {24'd0, data_o}, 32'h01);
        ready_i = 1'b1;
        @(posedge clk);
        #1;
        check("bp_refill_valid", {31'd0, valid_o}, 32'd1);
        check("bp_refill_data", {24'd0, data_o}, 32'h02);
        check("bp_refill_sel", {31'd0, sel_o}, 32'd1);
        check("bp_refill_a1", {31'd0, a1_o}, 32'd1);
        @(posedge clk);
        #1;
        check("bp_second_consumed", {31'd0, valid_o}, 32'd0);
        r1_i = 1'b0;
        wait_ack(1'b1, 1'b0, 20, n);
        check("bp_a1_fall_latency", n, 32'd3);

        // Reset while an ack is held
        do_reset();
        d0_i = 8'h5A;
        r0_i = 1'b1;
        wait_ack(1'b0, 1'b1, 20, n);
        check("midhold_grant", {31'd0, a0_o}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midhold_a0_cleared", {31'd0, a0_o}, 32'd0);
        check("midhold_valid_cleared", {31'd0, valid_o}, 32'd0);
        rst = 1'b0;
        wait_ack(1'b0, 1'b1, 20, n);
        check("midhold_regrant_latency", n, 32'd3);
        check("midhold_regrant_data", {24'd0, data_o}, 32'h5A);
        r0_i = 1'b0;
        wait_ack(1'b0, 1'b0, 20, n);
        check("midhold_release", {31'd0, a0_o}, 32'd0);

`ifdef HS_MERGE_CNT_EN
        // Grant counters and saturation
        do_reset();
        for (int i = 0; i < 5; i++) xfer(1'b0, 8'(i));
        for (int i = 0; i < 3; i++) xfer(1'b1, 8'(i));
        check("cnt0_value", {16'd0, cnt0_o}, 32'd5);
        check("cnt1_value", {16'd0, cnt1_o}, 32'd3);
        force dut.cnt0_q = 16'hFFFF;
        #1;
        release dut.cnt0_q;
        xfer(1'b0, 8'h77);
        check("cnt0_saturated", {16'd0, cnt0_o}, 32'h0000_FFFF);
`endif

        // Random traffic against the queue model
        do_reset();
        exp_q0.delete();
        exp_q1.delete();
        rx_cnt = 0;
        sb_en  = 1'b1;
        done0  = 1'b0;
        done1  = 1'b0;
        fork
            begin
                for (int i = 0; i < 500; i++) begin
                    xfer(1'b0, 8'($urandom));
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    #1;
                end
                done0 = 1'b1;
            end
            begin
                for (int i = 0; i < 500; i++) begin
                    xfer(1'b1, 8'($urandom));
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    #1;
                end
                done1 = 1'b1;
            end
            begin
                while (!(done0 && done1)) begin
                    @(posedge clk);
                    #1;
                    ready_i = ($urandom_range(0, 3) != 0);
                end
            end
        join
        ready_i = 1'b1;
        n = 0;
        while ((exp_q0.size() + exp_q1.size()) != 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
        check("rand_q0_drained", exp_q0.size(), 32'd0);
        check("rand_q1_drained", exp_q1.size(), 32'd0);
        check("rand_word_count", rx_cnt, 32'd1000);
        check("rand_slot_empty", {31'd0, valid_o}, 32'd0);
        sb_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
